// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-and-add sequential multiplier.
// Holds the controller state encoding, the default operand width and counter sizing.
package seq_mult_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH itself, so it needs room for WIDTH+1 codes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand registers, (WIDTH+1)-bit adder, right shifter and iteration counter
// for the shift-and-add multiplier; sequencing comes from the top-level FSM.
import seq_mult_pkg::*;

module seq_mult_datapath #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic [WIDTH-1:0] a_sum;

  // Partial-product add; c is the carry that the shift pulls back into A.
  always_comb begin
    {c, a_sum} = {1'b0, a_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
      cnt   <= '0;
    end else if (load) begin
      a_reg <= '0;
      q_reg <= q;
      m_reg <= m;
      cnt   <= CNT_W'(WIDTH);
    end else if (step) begin
      a_reg <= {c, a_sum[WIDTH-1:1]};
      q_reg <= {a_sum[0], q_reg[WIDTH-1:1]};
      cnt   <= cnt - 1'b1;
    end
  end

  assign product = {a_reg, q_reg};
  assign last    = (cnt == CNT_W'(1));

endmodule

// File: rtl/sequential_multiplier_4x4.sv
// Unsigned sequential multiplier, one multiplier bit per clock.
// Controller FSM and registered product/done outputs around seq_mult_datapath.
import seq_mult_pkg::*;

module sequential_multiplier_4x4 #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] product;

  // start is only honoured from IDLE, so in-flight operands are never disturbed.
  assign load = (state == IDLE) && start;
  assign step = (state == RUN);
  assign busy = (state == RUN);

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .m      (m),
    .q      (q),
    .product(product),
    .last   (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) state <= RUN;
        RUN:  if (last) state <= DONE;
        DONE: begin
          out   <= product;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiplier_4x4.sv
// Directed bench for sequential_multiplier_4x4: products, latency, busy width,
// ignored mid-run starts, asynchronous reset abort and a full operand sweep.
module tb_sequential_multiplier_4x4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] m = '0;
  logic [3:0] q = '0;
  logic [7:0] out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  sequential_multiplier_4x4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .m    (m),
    .q    (q),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch one multiply and wait for done; returns at the negedge where done is high.
  // With aligned=1 start is driven immediately (used for back-to-back in the done cycle).
  task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                         input string tag, input bit aligned);
    int lat;
    int busy_cycles;
    bit seen;
    if (!aligned) @(negedge clk);
    start = 1'b1; m = a; q = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; m = ~a; q = ~b;
    busy_cycles = busy ? 1 : 0;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat = i;
      end else if (busy) begin
        busy_cycles++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_out"}, out, exp);
      check({tag, "_lat"}, lat, 5);
      check({tag, "_busy"}, busy_cycles, 4);
    end
  endtask

  initial begin
    int dones;
    logic [7:0] cap;
    bit sweep_seen;
    int sweep_lat;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b1;

    // 13 x 11
    do_mult(4'd13, 4'd11, 8'h8F, "m13x11", 1'b0);
    @(negedge clk);
    check("hold_done_low", done, 1'b0);
    check("hold_out", out, 8'h8F);

    do_mult(4'd8, 4'd3, 8'h18, "m8x3", 1'b0);
    do_mult(4'd0, 4'd15, 8'h00, "m0x15", 1'b0);
    do_mult(4'd15, 4'd15, 8'hE1, "m15x15", 1'b0);
    do_mult(4'd1, 4'd1, 8'h01, "b2b_1x1", 1'b1);

    // Starts during RUN are ignored; operands wiggle every cycle.
    @(negedge clk);
    start = 1'b1; m = 4'd13; q = 4'd11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    cap = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i <= 3) begin
        start = 1'b1; m = 4'd2 + 4'(i); q = 4'd2 + 4'(2 * i);
      end else begin
        start = 1'b0; m = 4'(i); q = 4'(15 - i);
      end
      if (done) begin
        dones++;
        cap = out;
      end
    end
    check("ign_out", cap, 8'h8F);
    check("ign_dones", dones, 1);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; m = 4'd13; q = 4'd11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_out", out, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("arst_hold_out", out, 8'h00);
    do_mult(4'd7, 4'd9, 8'h3F, "m7x9", 1'b0);

    // Full operand sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        start = 1'b1; m = 4'(a); q = 4'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; m = 4'(b); q = 4'(a + 3);
        sweep_seen = 1'b0;
        sweep_lat = 0;
        for (int i = 1; i <= 12 && !sweep_seen; i++) begin
          @(posedge clk);
          @(negedge clk);
          if (done) begin
            sweep_seen = 1'b1;
            sweep_lat = i;
          end
        end
        if (!sweep_seen) begin
          check("sweep_timeout", 32'd0, 32'd1);
        end else begin
          check("sweep_out", out, 32'(a * b));
          check("sweep_lat", sweep_lat, 5);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
